// File: rtl/rs_serial_decoder.sv
`timescale 1ns/1ps
// Symbol-serial single-error-correcting Reed-Solomon decoder over GF(2^M).
// S1/S2 are accumulated by Horner's rule, then the error location is found by a linear search.
module rs_serial_decoder #(
  parameter int  M         = 3,
  parameter int  PRIM_POLY = 11,
  localparam int N         = (1 << M) - 1,
  localparam int W         = $clog2(N)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*M-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*M-1:0] out_data,
  output logic [1:0]     out_status,
  output logic [W-1:0]   err_pos,
  output logic [M-1:0]   err_val
);
  localparam logic [M:0]   POLY     = PRIM_POLY[M:0];
  localparam logic [W-1:0] LAST     = W'(N - 1);
  localparam logic [1:0]   ST_CLEAN = 2'd0;
  localparam logic [1:0]   ST_FIXED = 2'd1;
  localparam logic [1:0]   ST_FAIL  = 2'd2;

  typedef enum logic [2:0] {IDLE, SYND, DECIDE, SEARCH, DONE} state_t;

  state_t         state_reg;
  logic [N*M-1:0] word_reg;
  logic [M-1:0]   s1_reg;
  logic [M-1:0]   s2_reg;
  logic [M-1:0]   t_reg;
  logic [M-1:0]   e_reg;
  logic [W-1:0]   idx_reg;
  logic [W-1:0]   j_reg;

  logic [M-1:0]   sym [N];
  logic [N*M-1:0] fixed_word;

  function automatic logic [M-1:0] mul_alpha(input logic [M-1:0] x);
    mul_alpha = {x[M-2:0], 1'b0} ^ (x[M-1] ? POLY[M-1:0] : '0);
  endfunction

  function automatic logic [M-1:0] mul_alpha_inv(input logic [M-1:0] x);
    logic [M:0] t;
    // Adding the polynomial clears bit 0 whenever it is set, so the shift is exact.
    t = {1'b0, x} ^ (x[0] ? POLY : '0);
    mul_alpha_inv = t[M:1];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_sym
      assign sym[gi] = word_reg[gi*M +: M];
      assign fixed_word[gi*M +: M] = word_reg[gi*M +: M] ^ ((j_reg == W'(gi)) ? e_reg : '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      word_reg   <= '0;
      s1_reg     <= '0;
      s2_reg     <= '0;
      t_reg      <= '0;
      e_reg      <= '0;
      idx_reg    <= '0;
      j_reg      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_status <= ST_CLEAN;
      err_pos    <= '0;
      err_val    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            word_reg  <= in_data;
            s1_reg    <= '0;
            s2_reg    <= '0;
            idx_reg   <= LAST;
            in_ready  <= 1'b0;
            state_reg <= SYND;
          end
        end
        SYND: begin
          s1_reg  <= mul_alpha(s1_reg) ^ sym[idx_reg];
          s2_reg  <= mul_alpha(mul_alpha(s2_reg)) ^ sym[idx_reg];
          idx_reg <= idx_reg - 1'b1;
          if (idx_reg == '0) begin
            state_reg <= DECIDE;
          end
        end
        DECIDE: begin
          if ((s1_reg == '0) || (s2_reg == '0)) begin
            out_data   <= word_reg;
            out_status <= ((s1_reg == '0) && (s2_reg == '0)) ? ST_CLEAN : ST_FAIL;
            err_pos    <= '0;
            err_val    <= '0;
            out_valid  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            t_reg     <= s1_reg;
            e_reg     <= s1_reg;
            j_reg     <= '0;
            state_reg <= SEARCH;
          end
        end
        SEARCH: begin
          // T tracks S1*a^j; a match with S2 means the error sits at j with magnitude E.
          if (t_reg == s2_reg) begin
            out_data   <= fixed_word;
            out_status <= ST_FIXED;
            err_pos    <= j_reg;
            err_val    <= e_reg;
            out_valid  <= 1'b1;
            state_reg  <= DONE;
          end else if (j_reg == LAST) begin
            out_data   <= word_reg;
            out_status <= ST_FAIL;
            err_pos    <= '0;
            err_val    <= '0;
            out_valid  <= 1'b1;
            state_reg  <= DONE;
          end else begin
            t_reg <= mul_alpha(t_reg);
            e_reg <= mul_alpha_inv(e_reg);
            j_reg <= j_reg + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rs_serial_decoder.sv
`timescale 1ns/1ps
// Bench for rs_serial_decoder (M=3): a brute-force GF(8) model fills a scoreboard that each
// scenario task pops and compares against the captured result, including latency.
module tb_rs_serial_decoder;
  localparam int M    = 3;
  localparam int N    = 7;
  localparam int W    = 3;
  localparam int POLY = 11;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*M-1:0] in_data = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [N*M-1:0] out_data;
  logic [1:0]     out_status;
  logic [W-1:0]   err_pos;
  logic [M-1:0]   err_val;

  rs_serial_decoder #(.M(M), .PRIM_POLY(POLY)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_status(out_status), .err_pos(err_pos), .err_val(err_val)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [N*M-1:0] data;
    logic [1:0]     status;
    logic [W-1:0]   pos;
    logic [M-1:0]   val;
    logic [7:0]     lat;
  } res_t;

  res_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   acc_cyc  = 0;

  function automatic logic [M-1:0] gmul(input logic [M-1:0] a, input logic [M-1:0] b);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++) if (b[i]) p ^= ({{(M-1){1'b0}}, a} << i);
    for (int i = 2*M-2; i >= M; i--) if (p[i]) p ^= ((2*M-1)'(POLY) << (i - M));
    return p[M-1:0];
  endfunction

  function automatic logic [M-1:0] apow(input int k);
    logic [M-1:0] r;
    r = 3'd1;
    for (int i = 0; i < (k % N); i++) r = gmul(r, 3'd2);
    return r;
  endfunction

  // Reference decoder: direct syndrome sums, exhaustive location and magnitude search.
  function automatic res_t model(input logic [N*M-1:0] w);
    res_t m;
    logic [M-1:0] s1, s2, e;
    s1 = '0; s2 = '0; e = '0;
    for (int i = 0; i < N; i++) begin
      s1 ^= gmul(w[i*M +: M], apow(i));
      s2 ^= gmul(w[i*M +: M], apow(2*i));
    end
    m.data = w; m.status = 2'd0; m.pos = '0; m.val = '0; m.lat = 8'(N + 1);
    if (s1 == '0 && s2 == '0) return m;
    if (s1 == '0 || s2 == '0) begin
      m.status = 2'd2;
      return m;
    end
    for (int j = 0; j < N; j++) begin
      if (gmul(s1, apow(j)) == s2) begin
        for (int v = 1; v <= N; v++) if (gmul(3'(v), apow(j)) == s1) e = 3'(v);
        m.data[j*M +: M] ^= e;
        m.status = 2'd1; m.pos = 3'(j); m.val = e; m.lat = 8'(N + 2 + j);
        return m;
      end
    end
    m.status = 2'd2; m.lat = 8'(2*N + 1);
    return m;
  endfunction

  function automatic logic [N*M-1:0] encode(input logic [(N-2)*M-1:0] msg);
    logic [M-1:0]   g [3];
    logic [N*M-1:0] c;
    g[0] = gmul(apow(1), apow(2));
    g[1] = apow(1) ^ apow(2);
    g[2] = 3'd1;
    c = '0;
    for (int i = 0; i < N-2; i++)
      for (int k = 0; k < 3; k++) c[(i+k)*M +: M] ^= gmul(msg[i*M +: M], g[k]);
    return c;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("data=%h st=%0d pos=%0d val=%0d lat=%0d", r.data, r.status, r.pos, r.val, r.lat);
  endfunction

  // All tasks are entered and left at a falling edge.
  task automatic drive_word(input logic [N*M-1:0] w);
    int t = 0;
    while (!in_ready && t < 200) begin @(negedge clk); t++; end
    in_valid = 1'b1;
    in_data  = w;
    sb.push_back(model(w));
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = ~w;
    acc_cyc  = cyc;
  endtask

  task automatic capture(output res_t r, output bit got);
    got = 1'b0;
    for (int t = 0; t < 100; t++) begin
      if (out_valid) begin got = 1'b1; break; end
      @(negedge clk);
    end
    r.data = out_data; r.status = out_status; r.pos = err_pos; r.val = err_val;
    r.lat = 8'(cyc - acc_cyc);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({in_ready, out_valid, out_data, out_status, err_pos, err_val} !== {1'b1, 1'b0, {(N*M+2+W+M){1'b0}}}) begin
      n_fail++;
      $display("FAIL reset: rdy=%b vld=%b data=%h st=%0d pos=%0d val=%0d, expected rdy=1 vld=0 rest 0",
               in_ready, out_valid, out_data, out_status, err_pos, err_val);
    end
    reset = 1'b0;
    @(negedge clk);
    $display("reset: rdy=%b vld=%b", in_ready, out_valid);
  endtask

  task automatic test_clean();
    res_t r, e; bit got;
    drive_word('0);
    capture(r, got);
    e = sb.pop_front();
    n_checks++;
    if (!got || r !== e) begin n_fail++; $display("FAIL clean: got %s, expected %s", fmt(r), fmt(e)); end
    n_checks++;
    if (r.lat !== 8'd8 || r.status !== 2'd0) begin n_fail++; $display("FAIL clean_lat: got lat=%0d st=%0d, expected 8 0", r.lat, r.status); end
    $display("clean: %s", fmt(r));
    release_out();
  endtask

  task automatic test_single_error();
    res_t r, e; bit got; logic [N*M-1:0] w;
    w = '0; w[3*M +: M] = 3'b101;
    drive_word(w);
    capture(r, got);
    e = sb.pop_front();
    n_checks++;
    if (!got || r !== e) begin n_fail++; $display("FAIL single_error: got %s, expected %s", fmt(r), fmt(e)); end
    n_checks++;
    if ({r.data, r.status, r.pos, r.val, r.lat} !== {21'd0, 2'd1, 3'd3, 3'd5, 8'd12}) begin
      n_fail++; $display("FAIL single_error_fixed: got %s, expected data=0 st=1 pos=3 val=5 lat=12", fmt(r));
    end
    $display("single_error: %s", fmt(r));
    release_out();
  endtask

  task automatic test_zero_s1();
    res_t r, e; bit got; logic [N*M-1:0] w;
    w = '0; w[0 +: M] = 3'b010; w[M +: M] = 3'b001;
    drive_word(w);
    capture(r, got);
    e = sb.pop_front();
    n_checks++;
    if (!got || r !== e) begin n_fail++; $display("FAIL zero_s1: got %s, expected %s", fmt(r), fmt(e)); end
    n_checks++;
    if ({r.data, r.status, r.pos, r.val, r.lat} !== {w, 2'd2, 3'd0, 3'd0, 8'd8}) begin
      n_fail++; $display("FAIL zero_s1_fixed: got %s, expected data=%h st=2 pos=0 val=0 lat=8", fmt(r), w);
    end
    $display("zero_s1: %s", fmt(r));
    release_out();
  endtask

  task automatic test_codeword_error6();
    res_t r, e; bit got; logic [N*M-1:0] c, w;
    c = encode({3'd5, 3'd4, 3'd3, 3'd2, 3'd1});
    w = c; w[6*M +: M] ^= 3'b111;
    drive_word(w);
    capture(r, got);
    e = sb.pop_front();
    n_checks++;
    if (!got || r !== e) begin n_fail++; $display("FAIL codeword_e6: got %s, expected %s", fmt(r), fmt(e)); end
    n_checks++;
    if ({r.data, r.status, r.pos, r.val, r.lat} !== {c, 2'd1, 3'd6, 3'd7, 8'd15}) begin
      n_fail++; $display("FAIL codeword_e6_fixed: got %s, expected data=%h st=1 pos=6 val=7 lat=15", fmt(r), c);
    end
    $display("codeword_e6: %s", fmt(r));
    release_out();
  endtask

  task automatic test_backpressure();
    res_t r, e; bit got; logic [N*M-1:0] w;
    w = encode({3'd1, 3'd7, 3'd0, 3'd6, 3'd2});
    w[2*M +: M] ^= 3'd4;
    drive_word(w);
    capture(r, got);
    e = sb.pop_front();
    n_checks++;
    if (!got || r !== e) begin n_fail++; $display("FAIL backpressure: got %s, expected %s", fmt(r), fmt(e)); end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, in_ready, out_data, out_status, err_pos, err_val} !== {1'b1, 1'b0, r.data, r.status, r.pos, r.val}) begin
        n_fail++;
        $display("FAIL stall_%0d: vld=%b rdy=%b data=%h st=%0d pos=%0d val=%0d, expected vld=1 rdy=0 %s",
                 s, out_valid, in_ready, out_data, out_status, err_pos, err_val, fmt(r));
      end
    end
    release_out();
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL after_handshake: vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
    end
    $display("backpressure: %s", fmt(r));
  endtask

  task automatic test_reset_midword();
    res_t r, e; bit got; logic [N*M-1:0] w;
    w = '0; w[5*M +: M] = 3'd6;
    drive_word(w);
    while (cyc < acc_cyc + 3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    void'(sb.pop_front());
    n_checks++;
    if ({in_ready, out_valid, out_data, out_status} !== {1'b1, 1'b0, 21'd0, 2'd0}) begin
      n_fail++; $display("FAIL reset_mid: rdy=%b vld=%b data=%h st=%0d, expected rdy=1 vld=0 data=0 st=0",
                         in_ready, out_valid, out_data, out_status);
    end
    w = encode({3'd3, 3'd3, 3'd1, 3'd0, 3'd7});
    w[1*M +: M] ^= 3'd2;
    drive_word(w);
    capture(r, got);
    e = sb.pop_front();
    n_checks++;
    if (!got || r !== e) begin n_fail++; $display("FAIL reset_mid_next: got %s, expected %s", fmt(r), fmt(e)); end
    $display("reset_midword: %s", fmt(r));
    release_out();
  endtask

  task automatic test_back_to_back();
    res_t r, e; bit got; logic [N*M-1:0] w1, w2;
    w1 = encode({3'd2, 3'd2, 3'd2, 3'd2, 3'd2}); w1[4*M +: M] ^= 3'd1;
    w2 = encode({3'd6, 3'd5, 3'd4, 3'd3, 3'd2}); w2[0 +: M] ^= 3'd3;
    drive_word(w1);
    capture(r, got);
    e = sb.pop_front();
    n_checks++;
    if (!got || r !== e) begin n_fail++; $display("FAIL b2b_first: got %s, expected %s", fmt(r), fmt(e)); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = w2;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_fail++; $display("FAIL b2b_gap: vld=%b rdy=%b, expected vld=0 rdy=1", out_valid, in_ready);
    end
    sb.push_back(model(w2));
    @(negedge clk);
    in_valid = 1'b0; in_data = '0; acc_cyc = cyc;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: rdy=%b, expected 0", in_ready); end
    capture(r, got);
    e = sb.pop_front();
    n_checks++;
    if (!got || r !== e) begin n_fail++; $display("FAIL b2b_second: got %s, expected %s", fmt(r), fmt(e)); end
    $display("back_to_back: %s", fmt(r));
    release_out();
  endtask

  task automatic test_random();
    res_t r, e; bit got; logic [N*M-1:0] w; logic [(N-2)*M-1:0] msg;
    for (int k = 0; k < 16; k++) begin
      msg = 15'($urandom);
      w = encode(msg);
      for (int n = 0; n < int'($urandom_range(0, 2)); n++) w[$urandom_range(0, N-1)*M +: M] ^= 3'($urandom_range(1, N));
      drive_word(w);
      capture(r, got);
      e = sb.pop_front();
      n_checks++;
      if (!got || r !== e) begin n_fail++; $display("FAIL random_%0d: got %s, expected %s", k, fmt(r), fmt(e)); end
      $display("random_%0d: in=%h %s", k, w, fmt(r));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      release_out();
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_error();
    test_zero_s1();
    test_codeword_error6();
    test_backpressure();
    test_reset_midword();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rs_serial_decoder.md
# rs_serial_decoder

Parametrised, symbol-serial Reed–Solomon single-error-correcting decoder over GF(2^M). It is the next generation of the fixed GF(8), 7-symbol decoder. It accepts one full-length codeword through a valid/ready handshake and computes syndromes S1 and S2 serially. It then locates and corrects one symbol error by a sequential search, and returns the corrected word with a status code. It sits between the channel deserialiser and the payload extractor, and tolerates backpressure on its output.

## Interface
- M, 3: symbol width in bits, legal range 3..8.
- PRIM_POLY, 11 (x^3+x+1): primitive polynomial, M+1 bits, bit M set.
- N (localparam), 2^M-1: symbols per codeword.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high; clock clk.
- in_valid  in  1  codeword present on in_data.
- in_ready  out  1  decoder can accept; high only in IDLE.
- in_data  in  N*M  received word; symbol i at bits [i*M +: M] is the coefficient of x^i.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  N*M  corrected word; on uncorrectable status it equals the input unchanged.
- out_status  out  2  0 = clean, 1 = corrected, 2 = uncorrectable; 3 is never driven.
- err_pos  out  clog2(N)  corrected symbol index; 0 unless status is 1.
- err_val  out  M  error value XORed into that symbol; 0 unless status is 1.

## Operation
- Field: α is the root of PRIM_POLY. Addition is XOR. Multiplication by the constants α, α^2 and α^-1 uses fixed shift/reduce logic derived from PRIM_POLY. No log/inverse tables.
- States: IDLE, SYND, DECIDE, SEARCH, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready:
  - register in_data;
  - clear S1, S2;
  - set idx = N-1;
  - go to SYND.
- SYND: one symbol per cycle, Horner order from the highest index:
  - S1 <= S1·α ^ r[idx];
  - S2 <= S2·α^2 ^ r[idx];
  - idx decrements; after r[0] is consumed (N cycles), go to DECIDE.
  - Resulting syndromes: S1 = Σ r_i α^i, S2 = Σ r_i α^(2i).
- DECIDE (1 cycle):
  - S1 = S2 = 0: go to DONE with status 0.
  - Exactly one of S1, S2 is zero: go to DONE with status 2.
  - Otherwise: load T = S1, E = S1, j = 0, and go to SEARCH.
- SEARCH (1 cycle per candidate j):
  - If T == S2: symbol j ^= E, err_pos = j, err_val = E, go to DONE with status 1.
  - Else: T <= T·α, E <= E·α^-1, j++.
  - If j == N-1 and there is no match: go to DONE with status 2.
  - At a match, T = S1·α^j and E = S1·α^-j, which is the error magnitude.
- DONE: out_valid = 1. out_data, out_status, err_pos and err_val are held stable until out_ready. On out_valid && out_ready, go to IDLE.
- Words with two or more errors may be miscorrected as a single error. This is inherent to t = 1 and is not flagged.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, out_status 0, err_pos 0, err_val 0. Syndromes and counters are cleared.
- Reset in any state aborts the current word. The next cycle is IDLE with the outputs above, and any pending result is discarded.
- Latency, counted from the accepting edge to the first cycle out_valid is high:
  - clean or zero-syndrome uncorrectable: N+1;
  - corrected at position j: N+2+j;
  - search exhausted: 2N+1.
- in_ready is low from the accepting edge until the out_valid && out_ready handshake completes. A new word cannot be accepted in the same cycle as the output handshake; it is accepted at the earliest in the following IDLE cycle.
- in_data is sampled only at the accepting edge, so later changes on in_data have no effect.
- out_valid stays high until out_ready, even across many stall cycles. Outputs never change while out_valid && !out_ready.
- in_valid is ignored outside IDLE.

## Test plan
All scenarios use M = 3, PRIM_POLY = 11, N = 7.
- All-zero word accepted at cycle 0 -> out_valid at cycle 8; out_data 0; status 0; err_pos 0; err_val 0.
- All-zero word with symbol 3 = 3'b101 -> out_valid at cycle 12 (N+2+3); out_data all zero; status 1; err_pos 3; err_val 5.
- All-zero word with symbol 0 = 3'b010 and symbol 1 = 3'b001 (S1 = 0, S2 ≠ 0) -> out_valid at cycle 8; status 2; out_data equals the input.
- Single error 3'b111 at symbol 6 on a valid nonzero codeword -> original codeword restored; status 1; err_pos 6; err_val 7; latency 15.
- out_ready held low for 5 cycles after out_valid -> all outputs stable and in_ready 0 throughout; handshake on cycle 6; IDLE next cycle.
- reset asserted during SYND (cycle 4) -> next cycle IDLE, in_ready 1, out_valid 0; a following word decodes with normal latency.
